wb_regfile_unit: RTL and testbench
==================================

# wb_regfile_unit

Write-back stage and architectural register file for the pipelined MIPS CPU; it consumes the MEM/WB pipeline register outputs and serves the ID-stage operand reads. Each cycle it selects the write-back data and destination register, updates the 32×32 register file, and exports the write as a forwarding source. ID-stage reads bypass a same-cycle write, so no extra WB→ID forwarding path is needed. A retired-write counter supports debug and CPI measurement.

## Interface
- SP_INIT, 32'h0000_0000, reset value of r29 ($sp)
- LINK_OFFSET, 4, added to PC_IN to form link data
- CNT_W, 32, width of the retired-write counter
- clk  in  1  clock, all state updates on the rising edge
- reset  in  1  synchronous, active-high reset
- RegWrite_in  in  1  write enable from MEM/WB
- instruction_in  in  32  instruction in WB; rt = [20:16], rd = [15:11]
- RegDst_in  in  2  destination select: 00 rt, 01 rd, 10 r31, 11 reserved
- memToReg_in  in  2  data select: 00 ALU result, 01 load data, 10 link, 11 reserved
- ALUout_in  in  32  ALU result
- readdata_in  in  32  load data
- PC_IN  in  32  PC of the instruction in WB
- rs_addr  in  5  ID read port A address
- rt_addr  in  5  ID read port B address
- rs_data  out  32  port A data, combinational
- rt_data  out  32  port B data, combinational
- wb_wen  out  1  effective write enable, combinational, for the forwarding unit
- wb_dst  out  5  effective destination, combinational
- wb_data  out  32  selected write data, combinational
- wr_count  out  CNT_W  number of retired register writes

## Operation
- Destination: RegDst 00→rt, 01→rd, 10→5'd31. 11 forces the write off.
- Data: memToReg 00→ALUout_in, 01→readdata_in, 10→PC_IN+LINK_OFFSET (modulo 2^32). 11 forces the write off; wb_data = 0.
- wb_wen = RegWrite_in & legal RegDst & legal memToReg & (wb_dst ≠ 0) & ~reset.
- r0 is never written and always reads 0.
- Read ports: if wb_wen and the address equals wb_dst, return wb_data (write-through bypass). Otherwise return the stored value. Both ports may bypass in the same cycle.
- wr_count increments by 1 on each cycle with wb_wen=1 and wraps at 2^CNT_W−1 → 0.
- Reset: all registers are 0 except r29 = SP_INIT. wr_count = 0. Reset wins over a same-cycle write, and bypass is disabled while reset=1. After reset, rs_data/rt_data return 0, or SP_INIT for address 29.

## Timing
- Write latency: data is visible in storage on the edge after wb_wen is sampled. It is visible on the read ports in the same cycle through the bypass.
- Read latency: 0 cycles (combinational from the addresses and WB inputs).
- Only one write port, so no write-write conflict. A write to r0 with RegWrite_in=1 is a silent no-op and is not counted.
- Reset asserted mid-stream: the pending WB write is dropped. The first write after reset is the first cycle with reset=0.
- wr_count updates on the same edge as the register write.

## Structure
- The shared package mips_pkg holds:
  - REGDST_RT/RD/RA and MEM2REG_ALU/MEM/LINK encodings.
  - REG_ZERO=0, REG_SP=29, REG_RA=31.
  - The instruction field slice positions.
- Sub-module regfile_32x32: 1 write port, 2 combinational read ports, r0 hardwired to 0, synchronous reset with the SP_INIT parameter. The selection logic, bypass and counter live in wb_regfile_unit.

## Test plan
- Reset, then read all 32 addresses: every register reads 0 except r29 = SP_INIT. wr_count = 0.
- ALU write: RegWrite=1, RegDst=01, rd=8, memToReg=00, ALUout=32'hDEAD_BEEF, rs_addr=8 in the same cycle → rs_data = DEADBEEF in the same cycle (bypass). Next cycle with RegWrite=0 → still DEADBEEF. wr_count = 1.
- Link write: RegDst=10, memToReg=10, PC_IN=32'hFFFF_FFFC → r31 = 0 (wrap). Then PC_IN=32'h0040_0010 → r31 = 32'h0040_0014.
- Load to rt=0: RegDst=00, instruction[20:16]=0, memToReg=01, readdata=32'h1234 → wb_wen=0, r0 reads 0, wr_count unchanged.
- Reserved encodings: RegDst=11 or memToReg=11 with RegWrite=1 → no write, wb_wen=0, wb_data=0 when memToReg=11.
- Reset coincident with a write to r5 = 32'hA5A5_A5A5 → r5 = 0 after the edge, wr_count = 0, and rs_data = 0 during the reset cycle.

Source files
------------

// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_pkg
//  Description : Shared encodings, register indices and instruction field
//                positions for the pipelined MIPS datapath.
//  Revision    : 1.0
// ============================================================================
package mips_pkg;

    typedef enum logic [1:0] {
        REGDST_RT   = 2'b00,
        REGDST_RD   = 2'b01,
        REGDST_RA   = 2'b10,
        REGDST_RSVD = 2'b11
    } regdst_e;

    typedef enum logic [1:0] {
        MEM2REG_ALU  = 2'b00,
        MEM2REG_MEM  = 2'b01,
        MEM2REG_LINK = 2'b10,
        MEM2REG_RSVD = 2'b11
    } mem2reg_e;

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam logic [4:0] REG_SP   = 5'd29;
    localparam logic [4:0] REG_RA   = 5'd31;

    localparam int RT_MSB = 20;
    localparam int RT_LSB = 16;
    localparam int RD_MSB = 15;
    localparam int RD_LSB = 11;

    function automatic logic [4:0] instr_rt(input logic [31:0] instr);
        return instr[RT_MSB:RT_LSB];
    endfunction

    function automatic logic [4:0] instr_rd(input logic [31:0] instr);
        return instr[RD_MSB:RD_LSB];
    endfunction

endpackage : mips_pkg
`default_nettype wire

// File: rtl/regfile_32x32.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_32x32
//  Description : 32x32 register file, one write port, two combinational read
//                ports, r0 hardwired to zero, r29 resets to SP_INIT.
//  Revision    : 1.0
// ============================================================================
module regfile_32x32
    import mips_pkg::*;
#(
    parameter logic [31:0] SP_INIT = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata,
    input  logic [4:0]  raddr_a,
    input  logic [4:0]  raddr_b,
    output logic [31:0] rdata_a,
    output logic [31:0] rdata_b
);

    logic [31:0] r_regs [32];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                r_regs[i] <= (5'(i) == REG_SP) ? SP_INIT : 32'h0000_0000;
            end
        end else if (we && (waddr != REG_ZERO)) begin
            r_regs[waddr] <= wdata;
        end
    end

    assign rdata_a = (raddr_a == REG_ZERO) ? 32'h0000_0000 : r_regs[raddr_a];
    assign rdata_b = (raddr_b == REG_ZERO) ? 32'h0000_0000 : r_regs[raddr_b];

endmodule : regfile_32x32
`default_nettype wire

// File: rtl/wb_regfile_unit.sv
`default_nettype none
// ============================================================================
//  Module      : wb_regfile_unit
//  Description : Write-back selection, architectural register file with
//                write-through read bypass, and retired-write counter.
//  Revision    : 1.0
// ============================================================================
module wb_regfile_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] SP_INIT     = 32'h0000_0000,
    parameter logic [31:0] LINK_OFFSET = 32'd4,
    parameter int          CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             RegWrite_in,
    input  logic [31:0]      instruction_in,
    input  logic [1:0]       RegDst_in,
    input  logic [1:0]       memToReg_in,
    input  logic [31:0]      ALUout_in,
    input  logic [31:0]      readdata_in,
    input  logic [31:0]      PC_IN,
    input  logic [4:0]       rs_addr,
    input  logic [4:0]       rt_addr,
    output logic [31:0]      rs_data,
    output logic [31:0]      rt_data,
    output logic             wb_wen,
    output logic [4:0]       wb_dst,
    output logic [31:0]      wb_data,
    output logic [CNT_W-1:0] wr_count
);

    localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

    logic             w_dst_legal;
    logic             w_data_legal;
    logic [31:0]      w_rf_rs;
    logic [31:0]      w_rf_rt;
    logic [CNT_W-1:0] r_wr_count;

    // Opcode/funct/shamt bits are not consumed in this stage.
    logic w_unused_instr;
    assign w_unused_instr = ^{instruction_in[31:21], instruction_in[10:0]};

    always_comb begin
        wb_dst      = REG_ZERO;
        w_dst_legal = 1'b0;
        unique case (regdst_e'(RegDst_in))
            REGDST_RT: begin
                wb_dst      = instr_rt(instruction_in);
                w_dst_legal = 1'b1;
            end
            REGDST_RD: begin
                wb_dst      = instr_rd(instruction_in);
                w_dst_legal = 1'b1;
            end
            REGDST_RA: begin
                wb_dst      = REG_RA;
                w_dst_legal = 1'b1;
            end
            default: begin
                wb_dst      = REG_ZERO;
                w_dst_legal = 1'b0;
            end
        endcase
    end

    always_comb begin
        wb_data      = 32'h0000_0000;
        w_data_legal = 1'b0;
        unique case (mem2reg_e'(memToReg_in))
            MEM2REG_ALU: begin
                wb_data      = ALUout_in;
                w_data_legal = 1'b1;
            end
            MEM2REG_MEM: begin
                wb_data      = readdata_in;
                w_data_legal = 1'b1;
            end
            MEM2REG_LINK: begin
                wb_data      = PC_IN + LINK_OFFSET;
                w_data_legal = 1'b1;
            end
            default: begin
                wb_data      = 32'h0000_0000;
                w_data_legal = 1'b0;
            end
        endcase
    end

    // Gating with ~reset also disables the read bypass during reset.
    assign wb_wen = RegWrite_in & w_dst_legal & w_data_legal
                  & (wb_dst != REG_ZERO) & ~reset;

    regfile_32x32 #(
        .SP_INIT (SP_INIT)
    ) u_regfile (
        .clk     (clk),
        .reset   (reset),
        .we      (wb_wen),
        .waddr   (wb_dst),
        .wdata   (wb_data),
        .raddr_a (rs_addr),
        .raddr_b (rt_addr),
        .rdata_a (w_rf_rs),
        .rdata_b (w_rf_rt)
    );

    assign rs_data = (wb_wen && (rs_addr == wb_dst)) ? wb_data : w_rf_rs;
    assign rt_data = (wb_wen && (rt_addr == wb_dst)) ? wb_data : w_rf_rt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_count <= '0;
        end else if (wb_wen) begin
            r_wr_count <= r_wr_count + c_cnt_one;
        end
    end

    assign wr_count = r_wr_count;

endmodule : wb_regfile_unit
`default_nettype wire

// File: tb/tb_wb_regfile_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wb_regfile_unit
//  Description : Directed self-checking bench for wb_regfile_unit.
//  Revision    : 1.0
// ============================================================================
module tb_wb_regfile_unit;

    localparam logic [31:0] c_sp_init = 32'h7FFF_EFFC;

    logic        clk = 1'b0;
    logic        reset;
    logic        RegWrite_in;
    logic [31:0] instruction_in;
    logic [1:0]  RegDst_in;
    logic [1:0]  memToReg_in;
    logic [31:0] ALUout_in;
    logic [31:0] readdata_in;
    logic [31:0] PC_IN;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        wb_wen;
    logic [4:0]  wb_dst;
    logic [31:0] wb_data;
    logic [31:0] wr_count;

    int n_cmp = 0;
    int n_err = 0;

    wb_regfile_unit #(
        .SP_INIT     (c_sp_init),
        .LINK_OFFSET (32'd4),
        .CNT_W       (32)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .RegWrite_in    (RegWrite_in),
        .instruction_in (instruction_in),
        .RegDst_in      (RegDst_in),
        .memToReg_in    (memToReg_in),
        .ALUout_in      (ALUout_in),
        .readdata_in    (readdata_in),
        .PC_IN          (PC_IN),
        .rs_addr        (rs_addr),
        .rt_addr        (rt_addr),
        .rs_data        (rs_data),
        .rt_data        (rt_data),
        .wb_wen         (wb_wen),
        .wb_dst         (wb_dst),
        .wb_data        (wb_data),
        .wr_count       (wr_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge, then settle inputs 1ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset          = 1'b1;
        RegWrite_in    = 1'b0;
        instruction_in = 32'h0;
        RegDst_in      = 2'b00;
        memToReg_in    = 2'b00;
        ALUout_in      = 32'h0;
        readdata_in    = 32'h0;
        PC_IN          = 32'h0;
        rs_addr        = 5'd0;
        rt_addr        = 5'd0;
        tick();
        tick();
        reset = 1'b0;

        // Reset image of every register through both ports
        for (int i = 0; i < 32; i++) begin
            rs_addr = 5'(i);
            rt_addr = 5'(31 - i);
            #1;
            check($sformatf("rst_rs[%0d]", i), rs_data, (i == 29) ? c_sp_init : 32'h0);
            check($sformatf("rst_rt[%0d]", 31 - i), rt_data, ((31 - i) == 29) ? c_sp_init : 32'h0);
        end
        check("rst_count", wr_count, 32'd0);

        // ALU write to rd=8 with same-cycle bypass
        RegWrite_in    = 1'b1;
        RegDst_in      = 2'b01;
        memToReg_in    = 2'b00;
        instruction_in = 32'h0000_4000;
        ALUout_in      = 32'hDEAD_BEEF;
        rs_addr        = 5'd8;
        rt_addr        = 5'd9;
        #1;
        check("alu_wen", {31'd0, wb_wen}, 32'd1);
        check("alu_dst", {27'd0, wb_dst}, 32'd8);
        check("alu_bypass_rs", rs_data, 32'hDEAD_BEEF);
        check("alu_rt_other", rt_data, 32'h0);
        tick();
        RegWrite_in = 1'b0;
        #1;
        check("alu_stored", rs_data, 32'hDEAD_BEEF);
        check("alu_count", wr_count, 32'd1);

        // Link write wrapping to zero, then normal link write
        RegWrite_in = 1'b1;
        RegDst_in   = 2'b10;
        memToReg_in = 2'b10;
        PC_IN       = 32'hFFFF_FFFC;
        rs_addr     = 5'd31;
        #1;
        check("link_wrap_dst", {27'd0, wb_dst}, 32'd31);
        check("link_wrap_data", wb_data, 32'h0);
        tick();
        PC_IN = 32'h0040_0010;
        #1;
        check("link_prev_stored", rt_data, 32'h0);
        check("link_bypass", rs_data, 32'h0040_0014);
        tick();
        RegWrite_in = 1'b0;
        #1;
        check("link_stored", rs_data, 32'h0040_0014);
        check("link_count", wr_count, 32'd3);

        // Load to rt=0 is a silent no-op
        RegWrite_in    = 1'b1;
        RegDst_in      = 2'b00;
        memToReg_in    = 2'b01;
        instruction_in = 32'h0000_0000;
        readdata_in    = 32'h0000_1234;
        rs_addr        = 5'd0;
        #1;
        check("r0_wen", {31'd0, wb_wen}, 32'd0);
        check("r0_read", rs_data, 32'h0);
        tick();
        check("r0_read_after", rs_data, 32'h0);
        check("r0_count", wr_count, 32'd3);

        // Load to rt=6
        instruction_in = 32'h0006_0000;
        rs_addr        = 5'd6;
        #1;
        check("ld_wen", {31'd0, wb_wen}, 32'd1);
        check("ld_dst", {27'd0, wb_dst}, 32'd6);
        tick();
        RegWrite_in = 1'b0;
        #1;
        check("ld_stored", rs_data, 32'h0000_1234);
        check("ld_count", wr_count, 32'd4);

        // Reserved RegDst
        RegWrite_in    = 1'b1;
        RegDst_in      = 2'b11;
        memToReg_in    = 2'b00;
        instruction_in = 32'h0000_4000;
        ALUout_in      = 32'h0000_FFFF;
        rs_addr        = 5'd8;
        #1;
        check("rsvd_dst_wen", {31'd0, wb_wen}, 32'd0);
        check("rsvd_dst_rs", rs_data, 32'hDEAD_BEEF);
        tick();
        check("rsvd_dst_count", wr_count, 32'd4);

        // Reserved memToReg
        RegDst_in   = 2'b01;
        memToReg_in = 2'b11;
        #1;
        check("rsvd_m2r_wen", {31'd0, wb_wen}, 32'd0);
        check("rsvd_m2r_data", wb_data, 32'h0);
        check("rsvd_m2r_rs", rs_data, 32'hDEAD_BEEF);
        tick();
        check("rsvd_m2r_stored", rs_data, 32'hDEAD_BEEF);
        check("rsvd_m2r_count", wr_count, 32'd4);

        // Both ports bypass the same write
        memToReg_in    = 2'b00;
        instruction_in = 32'h0000_4800;
        ALUout_in      = 32'hCAFE_F00D;
        rs_addr        = 5'd9;
        rt_addr        = 5'd9;
        #1;
        check("dual_rs", rs_data, 32'hCAFE_F00D);
        check("dual_rt", rt_data, 32'hCAFE_F00D);
        tick();
        check("dual_count", wr_count, 32'd5);

        // Reset coincident with a write to r5
        reset          = 1'b1;
        RegDst_in      = 2'b00;
        memToReg_in    = 2'b00;
        instruction_in = 32'h0005_0000;
        ALUout_in      = 32'hA5A5_A5A5;
        rs_addr        = 5'd5;
        rt_addr        = 5'd8;
        #1;
        check("rstw_wen", {31'd0, wb_wen}, 32'd0);
        check("rstw_rs", rs_data, 32'h0);
        tick();
        reset       = 1'b0;
        RegWrite_in = 1'b0;
        #1;
        check("rstw_r5", rs_data, 32'h0);
        check("rstw_r8", rt_data, 32'h0);
        check("rstw_count", wr_count, 32'd0);
        rs_addr = 5'd29;
        rt_addr = 5'd9;
        #1;
        check("rstw_sp", rs_data, c_sp_init);
        check("rstw_r9", rt_data, 32'h0);

        // First write after reset counts from zero
        RegWrite_in    = 1'b1;
        RegDst_in      = 2'b01;
        instruction_in = 32'h0000_5000;
        ALUout_in      = 32'h1357_9BDF;
        tick();
        RegWrite_in = 1'b0;
        rs_addr     = 5'd10;
        #1;
        check("post_rst_r10", rs_data, 32'h1357_9BDF);
        check("post_rst_count", wr_count, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_wb_regfile_unit
`default_nettype wire
